loop_counter: RTL and testbench

Parametrised, synthesisable loop/step counter for stimulus and sequencing. On a start pulse it loads an initial value, then applies a signed step every PERIOD clocks for a programmed number of iterations, with wrap or saturate arithmetic. It reports busy, a per-update tick and a done pulse. It replaces hand-written timed for-loops in benches, and the same block can be instantiated in RTL as a programmable sequencer.

---
 rtl/loop_counter_if.sv | 32 +++
 rtl/loop_counter.sv | 158 +++++++++++++++
 tb/tb_loop_counter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/loop_counter_if.sv
// Control/status bundle for loop_counter: run parameters in, counter state and pulses out.
interface loop_counter_if #(
    parameter int WIDTH  = 4,
    parameter int ITER_W = 8,
    parameter int PER_W  = 8
);
    logic              start;
    logic              stop;
    logic [WIDTH-1:0]  init;
    logic [WIDTH-1:0]  step;
    logic              dir;
    logic              sat_mode;
    logic [ITER_W-1:0] iter;
    logic [PER_W-1:0]  period;

    logic [WIDTH-1:0]  count;
    logic [ITER_W-1:0] iter_cnt;
    logic              busy;
    logic              tick;
    logic              done;
    logic              sat;

    modport master (
        output start, stop, init, step, dir, sat_mode, iter, period,
        input  count, iter_cnt, busy, tick, done, sat
    );

    modport slave (
        input  start, stop, init, step, dir, sat_mode, iter, period,
        output count, iter_cnt, busy, tick, done, sat
    );
endinterface

// File: rtl/loop_counter.sv
// Programmable loop/step counter: loads init on start, then applies a signed step
// every PERIOD clocks for N iterations with wrap or saturate arithmetic.
module loop_counter #(
    parameter int WIDTH  = 4,
    parameter int ITER_W = 8,
    parameter int PER_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    loop_counter_if.slave   bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  step_q, step_d;
    logic              dir_q, dir_d;
    logic              sat_mode_q, sat_mode_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [ITER_W-1:0] iter_n_q, iter_n_d;
    logic [PER_W-1:0]  pcnt_q, pcnt_d;
    logic [PER_W-1:0]  reload_q, reload_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              sat_q, sat_d;

    logic              accept;
    logic              update;
    logic              last_update;
    logic [PER_W-1:0]  period_m1;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic [WIDTH-1:0]  next_val;
    logic              clamp;

    assign accept      = (state_q == ST_IDLE) && bus.start && !bus.stop;
    assign update      = (state_q == ST_RUN) && !bus.stop && (pcnt_q == '0);
    assign last_update = update && ((iter_cnt_q + ITER_W'(1)) == iter_n_q);
    // A zero period behaves as one: reload value clamps at zero.
    assign period_m1   = (bus.period == '0) ? '0 : bus.period - PER_W'(1);

    // Step arithmetic in WIDTH+1 bits so the carry/borrow flags the clamp.
    always_comb begin
        sum_ext  = {1'b0, count_q} + {1'b0, step_q};
        diff_ext = {1'b0, count_q} - {1'b0, step_q};
        if (!dir_q) begin
            clamp    = sat_mode_q && sum_ext[WIDTH];
            next_val = clamp ? '1 : sum_ext[WIDTH-1:0];
        end else begin
            clamp    = sat_mode_q && diff_ext[WIDTH];
            next_val = clamp ? '0 : diff_ext[WIDTH-1:0];
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            step_q     <= '0;
            dir_q      <= 1'b0;
            sat_mode_q <= 1'b0;
            iter_cnt_q <= '0;
            iter_n_q   <= '0;
            pcnt_q     <= '0;
            reload_q   <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            sat_mode_q <= sat_mode_d;
            iter_cnt_q <= iter_cnt_d;
            iter_n_q   <= iter_n_d;
            pcnt_q     <= pcnt_d;
            reload_q   <= reload_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (bus.iter != '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop || last_update) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values and registered pulses.
    always_comb begin
        count_d    = count_q;
        step_d     = step_q;
        dir_d      = dir_q;
        sat_mode_d = sat_mode_q;
        iter_cnt_d = iter_cnt_q;
        iter_n_d   = iter_n_q;
        pcnt_d     = pcnt_q;
        reload_d   = reload_q;
        sat_d      = sat_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;

        if (accept) begin
            count_d    = bus.init;
            step_d     = bus.step;
            dir_d      = bus.dir;
            sat_mode_d = bus.sat_mode;
            iter_n_d   = bus.iter;
            reload_d   = period_m1;
            pcnt_d     = period_m1;
            iter_cnt_d = '0;
            sat_d      = 1'b0;
            // An empty run completes immediately without entering RUN.
            done_d     = (bus.iter == '0);
        end else if ((state_q == ST_RUN) && !bus.stop) begin
            if (update) begin
                count_d    = next_val;
                iter_cnt_d = iter_cnt_q + ITER_W'(1);
                sat_d      = sat_q | clamp;
                pcnt_d     = reload_q;
                tick_d     = 1'b1;
                done_d     = last_update;
            end else begin
                pcnt_d = pcnt_q - PER_W'(1);
            end
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        bus.count    = count_q;
        bus.iter_cnt = iter_cnt_q;
        bus.busy     = (state_q == ST_RUN);
        bus.tick     = tick_q;
        bus.done     = done_q;
        bus.sat      = sat_q;
    end

endmodule

// File: tb/tb_loop_counter.sv
// Directed bench for loop_counter: timed runs, wrap/saturate, abort, edge cases, async reset.
module tb_loop_counter;

    localparam int WIDTH  = 4;
    localparam int ITER_W = 8;
    localparam int PER_W  = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    loop_counter_if #(.WIDTH(WIDTH), .ITER_W(ITER_W), .PER_W(PER_W)) bus ();

    loop_counter #(.WIDTH(WIDTH), .ITER_W(ITER_W), .PER_W(PER_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setup(input int i_init, input int i_step, input int i_dir,
                         input int i_sat, input int i_iter, input int i_per);
        bus.init     = WIDTH'(i_init);
        bus.step     = WIDTH'(i_step);
        bus.dir      = i_dir[0];
        bus.sat_mode = i_sat[0];
        bus.iter     = ITER_W'(i_iter);
        bus.period   = PER_W'(i_per);
    endtask

    // Called just after a falling edge; returns just after the edge that samples start.
    task automatic start_run();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_edges, output int done_edge, output int ticks);
        done_edge = -1;
        ticks     = 0;
        for (int e = 1; e <= max_edges; e++) begin
            @(negedge clk);
            if (bus.tick) ticks++;
            if (bus.done) begin
                done_edge = e;
                break;
            end
        end
        if (done_edge < 0) check("timeout", 0, 1);
    endtask

    initial begin
        int done_edge;
        int ticks;
        int first_cnt;
        bit seen_done;

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        setup(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_count", bus.count, 0);
        check("rst_iter_cnt", bus.iter_cnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_done", bus.done, 0);
        check("rst_sat", bus.sat, 0);
        rst = 1'b0;
        @(negedge clk);

        // Long timed run: 11 updates every 10 clocks.
        setup(0, 1, 0, 0, 11, 10);
        start_run();
        check("t1_busy_start", bus.busy, 1);
        done_edge = -1;
        ticks     = 0;
        first_cnt = -1;
        for (int e = 1; e <= 200; e++) begin
            @(negedge clk);
            if (e == 9) check("t1_before_first", bus.count, 0);
            if (e == 10) first_cnt = int'(bus.count);
            if (bus.tick) ticks++;
            if (bus.done) begin
                done_edge = e;
                break;
            end
        end
        check("t1_first_update", first_cnt, 1);
        check("t1_done_edge", done_edge, 110);
        check("t1_ticks", ticks, 11);
        check("t1_count", bus.count, 11);
        check("t1_iter_cnt", bus.iter_cnt, 11);
        check("t1_busy_end", bus.busy, 0);
        $display("run long: done_edge=%0d ticks=%0d count=%0d", done_edge, ticks, bus.count);
        @(negedge clk);
        check("t1_done_pulse", bus.done, 0);

        // Wrap through 15 -> 0.
        setup(0, 1, 0, 0, 20, 1);
        start_run();
        wait_done(100, done_edge, ticks);
        check("wrap_done_edge", done_edge, 20);
        check("wrap_count", bus.count, 4);
        check("wrap_sat", bus.sat, 0);
        $display("run wrap: done_edge=%0d count=%0d sat=%0d", done_edge, bus.count, bus.sat);

        // Saturate up, then saturate down restarted in the done cycle.
        @(negedge clk);
        setup(12, 3, 0, 1, 4, 1);
        start_run();
        wait_done(50, done_edge, ticks);
        check("satup_done_edge", done_edge, 4);
        check("satup_count", bus.count, 15);
        check("satup_sat", bus.sat, 1);
        $display("run sat up: count=%0d sat=%0d", bus.count, bus.sat);
        setup(2, 3, 1, 1, 4, 1);
        start_run();
        check("b2b_busy", bus.busy, 1);
        check("satdn_sat_cleared", bus.sat, 0);
        wait_done(50, done_edge, ticks);
        check("satdn_done_edge", done_edge, 4);
        check("satdn_count", bus.count, 0);
        check("satdn_sat", bus.sat, 1);
        $display("run sat down: count=%0d sat=%0d", bus.count, bus.sat);

        // Wrap-mode subtraction below zero.
        @(negedge clk);
        setup(2, 3, 1, 0, 1, 1);
        start_run();
        wait_done(10, done_edge, ticks);
        check("wrapdn_count", bus.count, 15);
        check("wrapdn_sat", bus.sat, 0);
        $display("run wrap down: count=%0d", bus.count);

        // Abort after the 3rd update; a mid-run start must be ignored.
        @(negedge clk);
        setup(5, 1, 0, 0, 10, 2);
        start_run();
        seen_done = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
            if (e == 3) begin
                bus.start = 1'b1;
                bus.init  = 4'd9;
            end
            if (e == 4) bus.start = 1'b0;
            if (e == 6) bus.stop = 1'b1;
        end
        bus.stop = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_count", bus.count, 8);
        check("abort_iter_cnt", bus.iter_cnt, 3);
        repeat (3) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_hold", bus.count, 8);
        $display("run abort: count=%0d iter_cnt=%0d", bus.count, bus.iter_cnt);

        // Zero iterations: done at the start edge, never busy.
        setup(7, 1, 0, 0, 0, 1);
        start_run();
        check("iter0_done", bus.done, 1);
        check("iter0_busy", bus.busy, 0);
        check("iter0_count", bus.count, 7);
        check("iter0_iter_cnt", bus.iter_cnt, 0);
        @(negedge clk);
        check("iter0_done_pulse", bus.done, 0);
        $display("run iter0: count=%0d", bus.count);

        // Zero period behaves as one.
        setup(0, 2, 0, 0, 3, 0);
        start_run();
        wait_done(20, done_edge, ticks);
        check("per0_done_edge", done_edge, 3);
        check("per0_count", bus.count, 6);
        check("per0_ticks", ticks, 3);
        $display("run period0: done_edge=%0d count=%0d", done_edge, bus.count);

        // start and stop together in IDLE.
        @(negedge clk);
        setup(3, 1, 0, 0, 2, 1);
        bus.stop = 1'b1;
        start_run();
        bus.stop = 1'b0;
        check("ss_busy", bus.busy, 0);
        check("ss_count", bus.count, 6);
        check("ss_done", bus.done, 0);
        $display("run start+stop: busy=%0d count=%0d", bus.busy, bus.count);

        // Asynchronous reset between edges mid-run.
        setup(1, 1, 0, 0, 50, 1);
        start_run();
        repeat (3) @(negedge clk);
        check("rr_pre_count", bus.count, 4);
        #2 rst = 1'b1;
        #1;
        check("rr_count", bus.count, 0);
        check("rr_busy", bus.busy, 0);
        check("rr_iter_cnt", bus.iter_cnt, 0);
        @(negedge clk);
        check("rr_hold", bus.count, 0);
        rst = 1'b0;
        setup(3, 1, 0, 0, 2, 1);
        start_run();
        wait_done(20, done_edge, ticks);
        check("rr_new_done_edge", done_edge, 2);
        check("rr_new_count", bus.count, 5);
        $display("run after reset: done_edge=%0d count=%0d", done_edge, bus.count);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
